spi_cmd_arbiter: RTL

SPI_CMD_ARBITER -- requirements
Module: spi_cmd_arbiter

---
 rtl/spi_cmd_arbiter_if.sv | 29 ++
 rtl/spi_cmd_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/spi_cmd_arbiter_if.sv
// Requester and SPI-engine signal bundle for spi_cmd_arbiter.
// The slave modport is the arbiter side; master is the requesters plus engine.
interface spi_cmd_arbiter_if;
  logic        req0;
  logic [47:0] cmd0;
  logic [8:0]  sreg0;
  logic        req1;
  logic [47:0] cmd1;
  logic [8:0]  sreg1;
  logic        done0;
  logic        done1;
  logic [7:0]  r1;
  logic        timeout;
  logic        busy;
  logic [47:0] spi_data;
  logic [8:0]  spi_statusreg;
  logic [2:0]  spi_flagreg;
  logic [7:0]  r1_resp;

  modport slave (
    input  req0, cmd0, sreg0, req1, cmd1, sreg1, spi_flagreg, r1_resp,
    output done0, done1, r1, timeout, busy, spi_data, spi_statusreg
  );

  modport master (
    output req0, cmd0, sreg0, req1, cmd1, sreg1, spi_flagreg, r1_resp,
    input  done0, done1, r1, timeout, busy, spi_data, spi_statusreg
  );
endinterface

// File: rtl/spi_cmd_arbiter.sv
// Two-requester SPI command arbiter with anti-starvation for requester 1.
// Optional WAIT-state abort enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_cmd_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input logic             spi_clk_i,
  input logic             spi_rst_i,
  spi_cmd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [47:0] cmd_q;
  logic [7:0]  sreg_hi_q;
  logic        owner;
  logic [1:0]  starve_cnt;
  logic [7:0]  r1_q;
  logic        req_any;
  logic        grant1;
  logic        opert_done;
  logic        tmo_hit;
  logic        tmo_q;

  assign req_any    = bus.req0 | bus.req1;
  // Requester 1 wins when alone or after two consecutive req0 grants it sat through.
  assign grant1     = bus.req1 & (~bus.req0 | (starve_cnt == 2'd2));
  assign opert_done = bus.spi_flagreg[1];

  logic unused_bits;
  assign unused_bits = ^{bus.spi_flagreg[2], bus.spi_flagreg[0], bus.sreg0[0], bus.sreg1[0]};

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign tmo_hit = (state == WAIT) & ~opert_done & (tmo_cnt == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (state == ISSUE)     tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + 16'd1;
      if (state == WAIT)      tmo_q   <= tmo_hit;
    end
  end
`else
  logic [15:0] unused_cfg;
  assign unused_cfg = TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
  assign tmo_q      = 1'b0;
`endif

  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (opert_done | tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      cmd_q      <= '0;
      sreg_hi_q  <= '0;
      owner      <= 1'b0;
      starve_cnt <= 2'd0;
      r1_q       <= 8'hFF;
    end else begin
      if (state == IDLE && req_any) begin
        cmd_q     <= grant1 ? bus.cmd1 : bus.cmd0;
        sreg_hi_q <= grant1 ? bus.sreg1[8:1] : bus.sreg0[8:1];
        owner     <= grant1;
        if (grant1 | ~bus.req1)       starve_cnt <= 2'd0;
        else if (starve_cnt != 2'd2)  starve_cnt <= starve_cnt + 2'd1;
      end
      // OPERT_DONE has priority over an abort landing on the same cycle.
      if (state == WAIT) begin
        if (opert_done)   r1_q <= bus.r1_resp;
        else if (tmo_hit) r1_q <= 8'hFF;
      end
    end
  end

  always_comb begin
    bus.done0         = 1'b0;
    bus.done1         = 1'b0;
    bus.timeout       = 1'b0;
    bus.busy          = (state != IDLE);
    bus.spi_data      = 48'hFFFF_FFFF_FFFF;
    bus.spi_statusreg = 9'h000;
    case (state)
      ISSUE, WAIT: begin
        bus.spi_data      = cmd_q;
        bus.spi_statusreg = {sreg_hi_q, 1'b1};
      end
      DONE: begin
        bus.spi_data      = cmd_q;
        bus.spi_statusreg = {sreg_hi_q, 1'b0};
        bus.done0         = ~owner;
        bus.done1         = owner;
        bus.timeout       = tmo_q;
      end
      default: ;
    endcase
  end

  assign bus.r1 = r1_q;

endmodule
